// File: rtl/sm4_pkg.sv
// Shared SM4 definitions for the round engine and its T-transform stage:
// S-box table, round count, FSM states, word type and a rotate helper.
package sm4_pkg;

   localparam int SM4_ROUNDS = 32;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [7:0] SBOX [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   function automatic word_t rotl(input word_t w, input int n);
      return (w << n) | (w >> (32 - n));
   endfunction

endpackage

// File: rtl/sm4_round_t.sv
// Combinational SM4 data-path T transform: byte-wise S-box substitution
// followed by the linear mix L(B) = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24.
module sm4_round_t
   import sm4_pkg::*;
(
   input  logic [31:0] x,
   output logic [31:0] y
);

   word_t b;

   always_comb begin
      b = {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
      y = b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
   end

endmodule

// File: rtl/sm4_round_core.sv
// Iterative SM4 round engine, one round per clock; keys are fetched by index.
// Define SM4_ABORT_EN to add an abort input that returns RUN/DONE to IDLE.
module sm4_round_core
   import sm4_pkg::*;
#(
   parameter int ROUNDS = SM4_ROUNDS,
   parameter int IDXW   = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            dec,
   input  logic [127:0]    din,
`ifdef SM4_ABORT_EN
   input  logic            abort,
`endif
   output logic            ready,
   output logic [IDXW-1:0] rk_idx,
   input  logic [31:0]     rk_in,
   output logic [127:0]    dout,
   output logic            dout_valid
);

   state_e          state_q, state_d;
   logic [IDXW-1:0] round_q, round_d;
   logic            dec_q, dec_d;
   word_t           x0_q, x1_q, x2_q, x3_q;
   word_t           x0_d, x1_d, x2_d, x3_d;
   word_t           t_out;
   logic [127:0]    dout_q, dout_d;
   logic            abort_req;

`ifdef SM4_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   sm4_round_t u_t (
      .x (x1_q ^ x2_q ^ x3_q ^ rk_in),
      .y (t_out)
   );

   always_comb begin
      state_d    = state_q;
      round_d    = round_q;
      dec_d      = dec_q;
      x0_d       = x0_q;
      x1_d       = x1_q;
      x2_d       = x2_q;
      x3_d       = x3_q;
      dout_d     = dout_q;
      dout_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               {x0_d, x1_d, x2_d, x3_d} = din;
               dec_d   = dec;
               round_d = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            x0_d    = x1_q;
            x1_d    = x2_q;
            x2_d    = x3_q;
            x3_d    = x0_q ^ t_out;
            round_d = round_q + 1'b1;
            if (round_q == IDXW'(ROUNDS - 1)) state_d = DONE;
         end
         DONE: begin
            // Registers now hold X32..X35; the result is the reversed order.
            dout_d     = {x3_q, x2_q, x1_q, x0_q};
            dout_valid = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (abort_req && (state_q != IDLE)) begin
         state_d    = IDLE;
         dout_d     = dout_q;
         dout_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         round_q <= '0;
         dec_q   <= 1'b0;
         x0_q    <= '0;
         x1_q    <= '0;
         x2_q    <= '0;
         x3_q    <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         dec_q   <= dec_d;
         x0_q    <= x0_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         x3_q    <= x3_d;
         dout_q  <= dout_d;
      end
   end

   // dout follows dout_d so the result is visible in the same cycle as dout_valid.
   assign ready  = (state_q == IDLE);
   assign rk_idx = dec_q ? (IDXW'(ROUNDS - 1) - round_q) : round_q;
   assign dout   = dout_d;

endmodule

// File: tb/tb_sm4_round_core.sv
// Directed bench for sm4_round_core with a local SM4 key-schedule model
// serving round keys by index.
module tb_sm4_round_core;

   localparam logic [127:0] MK = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;

   localparam logic [7:0] TB_SBOX [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         dec;
   logic [127:0] din;
   logic         ready;
   logic [4:0]   rk_idx;
   logic [31:0]  rk_in;
   logic [127:0] dout;
   logic         dout_valid;
`ifdef SM4_ABORT_EN
   logic         abort;
`endif

   logic [31:0]  rk_tab [32];
   logic [31:0]  kk [36];
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   sm4_round_core #(.ROUNDS(32), .IDXW(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .dec        (dec),
      .din        (din),
`ifdef SM4_ABORT_EN
      .abort      (abort),
`endif
      .ready      (ready),
      .rk_idx     (rk_idx),
      .rk_in      (rk_in),
      .dout       (dout),
      .dout_valid (dout_valid)
   );

   // Key unit model: combinational lookup by the requested index.
   assign rk_in = rk_tab[rk_idx];

   function automatic logic [31:0] tb_rotl(input logic [31:0] w, input int n);
      return (w << n) | (w >> (32 - n));
   endfunction

   function automatic logic [31:0] tb_tkey(input logic [31:0] a);
      logic [31:0] b;
      b = {TB_SBOX[a[31:24]], TB_SBOX[a[23:16]], TB_SBOX[a[15:8]], TB_SBOX[a[7:0]]};
      return b ^ tb_rotl(b, 13) ^ tb_rotl(b, 23);
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One block from accept to a few idle cycles after completion; optionally
   // pulses start (with junk data) during RUN to confirm it is ignored.
   task automatic run_block(input logic [127:0] blk, input logic d, input logic [127:0] exp,
                            input string tag, input bit rej);
      int lat = 0;
      int npulse = 0;
      logic idx_ok = 1'b1;
      logic rdy_ok = 1'b1;
      logic [127:0] got = '0;
      @(negedge clk);
      start = 1'b1; din = blk; dec = d;
      @(posedge clk);
      #1 start = 1'b0; din = ~blk; dec = ~d;
      for (int c = 1; c <= 36; c++) begin
         @(negedge clk);
         if (c <= 32 && rk_idx !== (d ? 5'(31 - (c - 1)) : 5'(c - 1))) idx_ok = 1'b0;
         if (c <= 33 && ready !== 1'b0) rdy_ok = 1'b0;
         if (dout_valid === 1'b1) begin
            npulse++;
            lat = c;
            got = dout;
         end
         start = rej && (c == 5 || c == 32);
      end
      chk({tag, "_latency"}, 128'(lat), 128'd33);
      chk({tag, "_pulses"}, 128'(npulse), 128'd1);
      chk({tag, "_dout"}, got, exp);
      chk({tag, "_rkidx_seq"}, 128'(idx_ok), 128'd1);
      chk({tag, "_ready_low"}, 128'(rdy_ok), 128'd1);
      chk({tag, "_ready_after"}, 128'(ready), 128'd1);
      chk({tag, "_dout_held"}, dout, exp);
   endtask

   initial begin
      int c1, c2, nv;
      logic hold_ok;
      logic [127:0] first, second, prior;
      logic [31:0] ck;

      kk[0] = MK[127:96] ^ 32'ha3b1bac6;
      kk[1] = MK[95:64]  ^ 32'h56aa3350;
      kk[2] = MK[63:32]  ^ 32'h677d9197;
      kk[3] = MK[31:0]   ^ 32'hb27022dc;
      for (int i = 0; i < 32; i++) begin
         ck = {8'((4 * i) * 7), 8'((4 * i + 1) * 7), 8'((4 * i + 2) * 7), 8'((4 * i + 3) * 7)};
         kk[i + 4] = kk[i] ^ tb_tkey(kk[i + 1] ^ kk[i + 2] ^ kk[i + 3] ^ ck);
         rk_tab[i] = kk[i + 4];
      end

      rst_n = 1'b0; start = 1'b0; dec = 1'b0; din = '0;
`ifdef SM4_ABORT_EN
      abort = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 128'(ready), 128'd1);
      chk("rst_valid", 128'(dout_valid), 128'd0);
      chk("rst_dout", dout, 128'd0);
      chk("rst_rkidx", 128'(rk_idx), 128'd0);
      rst_n = 1'b1;

      run_block(PT, 1'b0, CT, "enc", 1'b0);
      run_block(CT, 1'b1, PT, "dec", 1'b0);
      run_block(PT, 1'b0, CT, "busy", 1'b1);

      // Reset during round 17.
      @(negedge clk);
      start = 1'b1; din = CT; dec = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (18) @(negedge clk);
      chk("midrst_round", 128'(rk_idx), 128'd17);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_ready", 128'(ready), 128'd1);
      chk("midrst_dout", dout, 128'd0);
      chk("midrst_valid", 128'(dout_valid), 128'd0);
      chk("midrst_rkidx", 128'(rk_idx), 128'd0);
      nv = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (dout_valid === 1'b1) nv++;
      end
      chk("midrst_no_valid", 128'(nv), 128'd0);
      run_block(CT, 1'b1, PT, "post_rst", 1'b0);

      // Back-to-back: second start held from DONE into the following IDLE cycle.
      @(negedge clk);
      start = 1'b1; din = PT; dec = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      c1 = 0; c2 = 0; hold_ok = 1'b1; first = '0; second = '0;
      for (int c = 1; c <= 75; c++) begin
         @(negedge clk);
         if (dout_valid === 1'b1) begin
            if (c1 == 0) begin
               c1 = c; first = dout;
               start = 1'b1; din = CT; dec = 1'b1;
            end else begin
               c2 = c; second = dout;
            end
         end else if (c1 != 0 && c2 == 0 && dout !== first) begin
            hold_ok = 1'b0;
         end
         if (c1 != 0 && c == c1 + 2) start = 1'b0;
      end
      chk("b2b_first_lat", 128'(c1), 128'd33);
      chk("b2b_spacing", 128'(c2 - c1), 128'd34);
      chk("b2b_first", first, CT);
      chk("b2b_second", second, PT);
      chk("b2b_hold", 128'(hold_ok), 128'd1);

`ifdef SM4_ABORT_EN
      prior = dout;
      @(negedge clk);
      start = 1'b1; din = CT; dec = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (11) @(negedge clk);
      chk("abort_round", 128'(rk_idx), 128'd10);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_ready", 128'(ready), 128'd1);
      chk("abort_valid", 128'(dout_valid), 128'd0);
      chk("abort_dout", dout, prior);
      nv = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (dout_valid === 1'b1) nv++;
      end
      chk("abort_no_valid", 128'(nv), 128'd0);
      chk("abort_dout_held", dout, prior);
`else
      prior = '0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
